eth_tx_frame_sched: RTL
=======================

Name: eth_tx_frame_sched

Overview:
- Sequences frame transmission out of the 2 KiB TX byte buffer (512x32 write side, 8-bit read side).
- Accepts one frame descriptor at a time (start byte address, byte length).
- Drives the buffer's byte-read port, absorbing its 1-cycle read latency.
- Presents bytes to the MAC TX path on a valid/ready stream with a last flag; signals completion to the descriptor producer.

Parameters:
- ADDR_W, 11, byte address width into TX buffer (buffer depth 2**ADDR_W bytes).
- LEN_W, 12, descriptor length width (max frame 2**ADDR_W bytes).
- MIN_FRAME, 60, minimum frame bytes; used only with ETH_TX_PAD_EN.

Ports:
- clk  in  1  sole clock; same clock as buffer read port.
- rst  in  1  synchronous, active-high reset.
- desc_valid_i  in  1  descriptor offered.
- desc_ready_o  out  1  scheduler idle, descriptor accepted when valid&ready.
- desc_addr_i  in  ADDR_W  frame start byte address.
- desc_len_i  in  LEN_W  frame length in bytes.
- abort_i  in  1  drop current frame.
- mem_ena_o  out  1  buffer read enable.
- mem_addr_o  out  ADDR_W  buffer byte read address.
- mem_rdata_i  in  8  read byte, valid the cycle after mem_ena_o.
- tx_data_o  out  8  stream byte.
- tx_valid_o  out  1  stream valid.
- tx_last_o  out  1  final byte of frame.
- tx_ready_i  in  1  MAC accepts byte.
- done_o  out  1  one-cycle pulse after last byte handshake.
- busy_o  out  1  frame in progress.

Behaviour:
- Reset: desc_ready_o=0 during rst, 1 the cycle after. All other outputs 0; FSM=IDLE; counters and skid buffer cleared.
- FSM states: IDLE, STREAM, DRAIN.
- IDLE:
  - desc_ready_o=1.
  - On desc_valid_i&desc_ready_o, latch addr/len.
  - Go to STREAM if len!=0.
  - If len==0: pulse done_o next cycle, stay IDLE, no bytes emitted.
- STREAM:
  - Issue reads at mem_addr_o = start+n, n = bytes issued.
  - Address arithmetic is modulo 2**ADDR_W (ring wrap 2047->0).
  - Go to DRAIN once issued count == len.
- DRAIN: wait until the skid buffer empties with the last handshake; then pulse done_o and go to IDLE.
- Read issue rule: mem_ena_o=1 iff (skid occupancy + reads in flight − pop this cycle) < 2 and bytes remain.
  - With tx_ready_i held high, sustains 1 byte/cycle.
  - First tx_valid_o appears 2 cycles after descriptor acceptance.
- Skid buffer: 2 entries, FIFO order, written from mem_rdata_i one cycle after each issued read.
- Stream rules:
  - tx_valid_o, once high, holds with stable tx_data_o/tx_last_o until tx_ready_i (except abort).
  - tx_last_o=1 only on byte index len−1.
- done_o asserts in the cycle after the last handshake; desc_ready_o is 1 in that same cycle. This gives back-to-back frames with a 1-cycle gap.
- busy_o=1 in STREAM/DRAIN.
- abort_i (any state except IDLE):
  - Next cycle: skid flushed, in-flight read discarded, tx_valid_o=0, FSM=IDLE, no done_o.
  - abort_i in IDLE is ignored.
- Descriptors are not accepted while busy.
- rst mid-frame behaves identically to abort plus full reset values.
- Length counters LEN_W wide. len > 2**ADDR_W is clamped to 2**ADDR_W.

Optional Feature:
- ETH_TX_PAD_EN defined:
  - Frames with len < MIN_FRAME are extended to MIN_FRAME bytes.
  - Pad bytes are 8'h00, inserted directly into the skid buffer without memory reads (mem_ena_o=0 during pad).
  - tx_last_o is on byte MIN_FRAME−1.
  - len==0 emits no bytes and is not padded.
- Undefined: exactly len bytes emitted; no pad logic synthesized.

Decomposition:
- Package eth_tx_pkg:
  - ADDR_W/LEN_W defaults.
  - MIN_FRAME.
  - typedef enum for FSM state {IDLE, STREAM, DRAIN}.
  - typedef struct desc_t {addr, len}.
- Sub-module eth_tx_skid: 2-entry skid FIFO with push/pop/flush and occupancy output. Shares nothing else.

Test Plan:
- Desc addr=0x010, len=4, tx_ready_i=1 → mem_addr 0x010..0x013 on consecutive cycles; bytes B0..B3 on 4 consecutive cycles; tx_last on B3; done_o the cycle after.
- Desc addr=0x7FE, len=4 → read addresses 0x7FE, 0x7FF, 0x000, 0x001; data order preserved.
- len=8, tx_ready_i toggled 1,0,0,1,… → no byte lost or duplicated; tx_data_o stable while stalled; mem_ena_o never causes more than 2 buffered+in-flight.
- abort_i asserted after 3 of 10 bytes accepted → tx_valid_o=0 next cycle; no done_o; next descriptor accepted and streams correctly from its own address.
- Two descriptors back-to-back (len=1, len=2), desc_valid_i held → second accepted the cycle done_o pulses for first; 3 total bytes; two tx_last.
- ETH_TX_PAD_EN, len=10 → 60 bytes: 10 from memory, 50 of 0x00, tx_last on byte 59. Without macro → 10 bytes only. len=0 → done_o, no bytes in both builds.

Source files
------------

// File: rtl/eth_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : eth_tx_pkg
//  Brief    : Shared types and defaults for the Ethernet TX frame scheduler.
//             Optional feature macro: ETH_TX_PAD_EN (short-frame padding).
//  Revision : 1.0 - initial release
// ============================================================================
package eth_tx_pkg;

    localparam int DEF_ADDR_W    = 11;   // 2 KiB TX byte buffer
    localparam int DEF_LEN_W     = 12;   // holds lengths up to 2**DEF_ADDR_W
    localparam int DEF_MIN_FRAME = 60;   // pad target when padding is built in

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_LEN_W-1:0]  len;
    } desc_t;

endpackage
`default_nettype wire

// File: rtl/eth_tx_skid.sv
`default_nettype none
// ============================================================================
//  Module   : eth_tx_skid
//  Brief    : Two-entry FIFO skid buffer with push/pop/flush and occupancy.
//             Entry 0 is always the head; pops shift entry 1 down.
//  Revision : 1.0 - initial release
// ============================================================================
module eth_tx_skid #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_pushData,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_headData,
    output logic [1:0]       o_occ
);

    logic [WIDTH-1:0] r_ent0;
    logic [WIDTH-1:0] r_ent1;
    logic [1:0]       r_occ;

    // FIFO storage and occupancy; callers never push when full or pop when empty
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_occ  <= 2'd0;
            r_ent0 <= '0;
            r_ent1 <= '0;
        end else begin
            case ({i_push, i_pop})
                2'b10: begin
                    if (r_occ == 2'd0) r_ent0 <= i_pushData;
                    else               r_ent1 <= i_pushData;
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_ent0 <= r_ent1;
                    r_occ  <= r_occ - 2'd1;
                end
                2'b11: begin
                    if (r_occ == 2'd2) begin
                        r_ent0 <= r_ent1;
                        r_ent1 <= i_pushData;
                    end else begin
                        r_ent0 <= i_pushData;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_headData = r_ent0;
    assign o_occ      = r_occ;

endmodule
`default_nettype wire

// File: rtl/eth_tx_frame_sched.sv
`default_nettype none
// ============================================================================
//  Module   : eth_tx_frame_sched
//  Brief    : Streams one descriptor-defined frame at a time out of the TX
//             byte buffer onto a valid/ready byte stream with last flag.
//             Optional macro ETH_TX_PAD_EN pads short frames with 8'h00.
//  Revision : 1.0 - initial release
// ============================================================================
module eth_tx_frame_sched
    import eth_tx_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LEN_W  = DEF_LEN_W
`ifdef ETH_TX_PAD_EN
    , parameter int MIN_FRAME = DEF_MIN_FRAME
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              desc_valid_i,
    output logic              desc_ready_o,
    input  logic [ADDR_W-1:0] desc_addr_i,
    input  logic [LEN_W-1:0]  desc_len_i,
    input  logic              abort_i,
    output logic              mem_ena_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [7:0]        mem_rdata_i,
    output logic [7:0]        tx_data_o,
    output logic              tx_valid_o,
    output logic              tx_last_o,
    input  logic              tx_ready_i,
    output logic              done_o,
    output logic              busy_o
);

    localparam logic [LEN_W-1:0] c_BUF_BYTES = LEN_W'(2 ** ADDR_W);

    state_t            r_state;
    logic [ADDR_W-1:0] r_base;
    logic [LEN_W-1:0]  r_total;        // bytes to emit, including any pad
    logic [LEN_W-1:0]  r_issued;       // bytes issued (reads plus pad slots)
    logic              r_inFlight;     // a byte arrives on mem_rdata_i this cycle
    logic              r_inFlightLast;
    logic              r_done;

    logic [LEN_W-1:0]  w_clampLen;
    logic [LEN_W-1:0]  w_totalLen;
    logic [7:0]        w_rdByte;
    logic [8:0]        w_head;
    logic [8:0]        w_front;
    logic [1:0]        w_occ;
    logic              w_txValid;
    logic              w_pop;
    logic              w_skidPop;
    logic              w_push;
    logic              w_lastHs;
    logic              w_flush;
    logic              w_accept;
    logic              w_canIssue;

    assign w_clampLen = (desc_len_i > c_BUF_BYTES) ? c_BUF_BYTES : desc_len_i;

`ifdef ETH_TX_PAD_EN
    logic [LEN_W-1:0]  r_memLen;       // bytes that come from the buffer
    logic              r_inFlightPad;  // in-flight slot is a pad byte, not a read
    logic              w_isPad;

    assign w_totalLen = ((w_clampLen != '0) && (w_clampLen < LEN_W'(MIN_FRAME)))
                        ? LEN_W'(MIN_FRAME) : w_clampLen;
    assign w_isPad    = (r_issued >= r_memLen);
    assign w_rdByte   = r_inFlightPad ? 8'h00 : mem_rdata_i;
    assign mem_ena_o  = w_canIssue & ~w_isPad;
`else
    assign w_totalLen = w_clampLen;
    assign w_rdByte   = mem_rdata_i;
    assign mem_ena_o  = w_canIssue;
`endif

    // The arriving byte is presented directly when the skid is empty, which
    // hides the buffer's read latency; it is only stored if not taken at once.
    assign w_front    = (w_occ == 2'd0) ? {r_inFlightLast, w_rdByte} : w_head;
    assign w_txValid  = (w_occ != 2'd0) | r_inFlight;
    assign w_pop      = w_txValid & tx_ready_i;
    assign w_skidPop  = w_pop & (w_occ != 2'd0);
    assign w_push     = r_inFlight & ~(w_pop & (w_occ == 2'd0));
    assign w_lastHs   = w_pop & w_front[8];
    assign w_flush    = abort_i & (r_state != IDLE);
    assign w_accept   = desc_valid_i & desc_ready_o;

    // Keep buffered plus in-flight bytes at two or fewer after this cycle
    assign w_canIssue = (r_state == STREAM) & ~abort_i & (r_issued != r_total) &
                        (({1'b0, w_occ} + {2'b00, r_inFlight}) < (3'd2 + {2'b00, w_pop}));

    assign mem_addr_o   = mem_ena_o ? (r_base + r_issued[ADDR_W-1:0]) : '0;
    assign tx_valid_o   = w_txValid;
    assign tx_data_o    = w_txValid ? w_front[7:0] : 8'h00;
    assign tx_last_o    = w_txValid & w_front[8];
    assign desc_ready_o = (r_state == IDLE) & ~rst;
    assign busy_o       = (r_state != IDLE);
    assign done_o       = r_done;

    eth_tx_skid #(
        .WIDTH(9)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .i_flush    (w_flush),
        .i_push     (w_push),
        .i_pushData ({r_inFlightLast, w_rdByte}),
        .i_pop      (w_skidPop),
        .o_headData (w_head),
        .o_occ      (w_occ)
    );

    // Frame sequencing: descriptor capture, read issue tracking, completion
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_base         <= '0;
            r_total        <= '0;
            r_issued       <= '0;
            r_inFlight     <= 1'b0;
            r_inFlightLast <= 1'b0;
            r_done         <= 1'b0;
`ifdef ETH_TX_PAD_EN
            r_memLen       <= '0;
            r_inFlightPad  <= 1'b0;
`endif
        end else begin
            r_done         <= 1'b0;
            r_inFlight     <= w_canIssue;
            r_inFlightLast <= w_canIssue & (r_issued == r_total - 1'b1);
`ifdef ETH_TX_PAD_EN
            r_inFlightPad  <= w_canIssue & w_isPad;
`endif
            if (w_canIssue) r_issued <= r_issued + 1'b1;

            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_base   <= desc_addr_i;
                        r_total  <= w_totalLen;
                        r_issued <= '0;
`ifdef ETH_TX_PAD_EN
                        r_memLen <= w_clampLen;
`endif
                        if (w_clampLen == '0) r_done  <= 1'b1;
                        else                  r_state <= STREAM;
                    end
                end
                STREAM: begin
                    if (w_flush) begin
                        r_state    <= IDLE;
                        r_inFlight <= 1'b0;
                    end else if (w_canIssue && (r_issued + 1'b1 == r_total)) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_flush) begin
                        r_state    <= IDLE;
                        r_inFlight <= 1'b0;
                    end else if (w_lastHs) begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
